// File: rtl/gentest_rsearch.sv
// Reverse lookup for the gentest table. The block takes a target value and
// steps the table index upward, one entry per clock. It returns the lowest
// index whose table value equals the target, or reports that no entry matched.
module gentest_rsearch #(
    parameter int IDX_W = 4,
    parameter int VAL_W = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [VAL_W-1:0] req_value,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [VAL_W-1:0] tbl_value,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_found,
    output logic [IDX_W-1:0] res_idx,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_e;

    // The last index scanned. It is compared for equality so that the counter
    // never needs to step past it. This also covers DEPTH == 2**IDX_W, where
    // DEPTH itself would not fit in IDX_W bits.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [VAL_W-1:0]   target_q, target_d;
    logic               found_q, found_d;
    logic [IDX_W-1:0]   res_idx_q, res_idx_d;

    // Next-state logic: accept a request, scan the table, then hold the result until it is consumed.
    always_comb begin
        // NOTE: every variable gets a default before the case statement, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        target_d  = target_q;
        found_d   = found_q;
        res_idx_d = res_idx_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    target_d  = req_value;
                    cnt_d     = '0;
                    found_d   = 1'b0;
                    res_idx_d = '0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (tbl_value == target_q) begin
                    found_d   = 1'b1;
                    res_idx_d = cnt_q;
                    state_d   = S_DONE;
                end else if (cnt_q == LAST_IDX) begin
                    found_d   = 1'b0;
                    res_idx_d = '0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register. An asynchronous reset aborts any scan in progress and discards the captured target.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            target_q  <= '0;
            found_q   <= 1'b0;
            res_idx_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample its _d value from the same pre-edge state.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            target_q  <= target_d;
            found_q   <= found_d;
            res_idx_q <= res_idx_d;
        end
    end

    // Output decode. The request side stays closed while reset is asserted,
    // because the state register already reads IDLE during reset.
    always_comb begin
        req_ready = reset_n && (state_q == S_IDLE);
        busy      = (state_q == S_SCAN);
        res_valid = (state_q == S_DONE);
        res_found = found_q;
        res_idx   = res_idx_q;
        tbl_idx   = (state_q == S_IDLE) ? '0 : cnt_q;
    end

endmodule

// File: tb/tb_gentest_rsearch.sv
// Self-checking bench for gentest_rsearch. A behavioural table stands in for
// the gentest instance. Each search result is compared against a reference
// search that simply loops over that table.
module tb_gentest_rsearch;

    localparam int IDX_W = 4;
    localparam int VAL_W = 8;
    localparam int DEPTH = 16;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [VAL_W-1:0] req_value = '0;
    logic [IDX_W-1:0] tbl_idx;
    logic [VAL_W-1:0] tbl_value;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             res_found;
    logic [IDX_W-1:0] res_idx;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    int tbl_mode = 0;   // 0: idx*idx+1 (mod 256), 1: same folded mod 8 (many duplicates)
    int visited[$];

    gentest_rsearch #(.IDX_W(IDX_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_value (req_value),
        .tbl_idx   (tbl_idx),
        .tbl_value (tbl_value),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_found (res_found),
        .res_idx   (res_idx),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [VAL_W-1:0] tbl_fn(input int mode, input int i);
        int v;
        v = (i * i + 1) % 256;
        if (mode != 0) v = v % 8;
        return VAL_W'(v);
    endfunction

    // Stand-in for the combinational gentest lookup.
    always_comb tbl_value = tbl_fn(tbl_mode, int'(tbl_idx));

    // Reference search: the lowest matching index, or not found.
    function automatic void ref_search(input int mode, input logic [VAL_W-1:0] v,
                                       output bit found, output int idx);
        found = 1'b0;
        idx = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && tbl_fn(mode, i) == v) begin
                found = 1'b1;
                idx = i;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a request, starting just after a negedge. The task returns once the accept edge has passed.
    task automatic issue(input logic [VAL_W-1:0] v);
        int n;
        req_value = v;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("accept_timeout", n < 50, 1);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // Count the clock edges from the accept edge to res_valid, and record the indices visited.
    task automatic await_result(output int lat);
        lat = 1;
        visited.delete();
        while (!res_valid && lat < 40) begin
            if (busy) visited.push_back(int'(tbl_idx));
            @(negedge clock);
            lat++;
        end
        lat--;
        check("result_timeout", res_valid, 1);
    endtask

    task automatic check_result(input string tag, input logic [VAL_W-1:0] v, input int lat);
        bit ef;
        int ei;
        ref_search(tbl_mode, v, ef, ei);
        check({tag, "_found"}, res_found, ef);
        check({tag, "_idx"}, res_idx, ei);
        check({tag, "_latency"}, lat, ef ? ei + 1 : DEPTH);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        check("res_valid_dropped", res_valid, 0);
        check("ready_after_done", req_ready, 1);
    endtask

    task automatic search(input string tag, input logic [VAL_W-1:0] v);
        int lat;
        issue(v);
        await_result(lat);
        check_result(tag, v, lat);
        consume();
    endtask

    initial begin
        int lat;
        int n;
        logic [VAL_W-1:0] v;

        // Reset, then idle.
        repeat (3) @(negedge clock);
        check("rst_req_ready", req_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_tbl_idx", tbl_idx, 0);
        reset_n = 1'b1;
        #1;
        check("idle_req_ready", req_ready, 1);
        check("idle_res_valid", res_valid, 0);
        check("idle_tbl_idx", tbl_idx, 0);
        check("idle_busy", busy, 0);
        @(negedge clock);

        // Match at the first entry, in the middle of the table, and at the last entry.
        search("first", 8'd1);
        search("mid", 8'd50);
        search("last", 8'd226);

        // No match: the full table is scanned, each index exactly once and in order.
        issue(8'd3);
        await_result(lat);
        check_result("nomatch", 8'd3, lat);
        check("nomatch_visits", visited.size(), DEPTH);
        for (int i = 0; i < visited.size() && i < DEPTH; i++)
            check("nomatch_order", visited[i], i);
        consume();

        // Backpressure: the result is held while res_ready is low, and a pending request stays blocked.
        issue(8'd50);
        await_result(lat);
        check_result("bp", 8'd50, lat);
        req_value = 8'd10;
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_res_valid", res_valid, 1);
            check("bp_res_idx", res_idx, 7);
            check("bp_tbl_idx", tbl_idx, 7);
            check("bp_req_ready", req_ready, 0);
            @(negedge clock);
        end
        res_ready = 1'b1;
        @(negedge clock);
        res_ready = 1'b0;
        check("bp_released", res_valid, 0);
        issue(8'd10);
        await_result(lat);
        check_result("bp_second", 8'd10, lat);
        consume();

        // Reset in the middle of a scan.
        issue(8'd226);
        n = 0;
        while (tbl_idx != 4'd5 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("abort_reach_cnt5", n < 40, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_res_valid", res_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_tbl_idx", tbl_idx, 0);
        check("abort_req_ready", req_ready, 0);
        check("abort_res_found", res_found, 0);
        check("abort_res_idx", res_idx, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("abort_no_result", res_valid, 0);
        end
        reset_n = 1'b1;
        #1;
        check("abort_ready", req_ready, 1);
        @(negedge clock);
        check("abort_still_idle", res_valid, 0);
        search("after_abort", 8'd17);

        // Randomised searches. The duplicate-heavy table exercises the rule that the lowest index wins.
        for (int k = 0; k < 24; k++) begin
            tbl_mode = int'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0)
                v = tbl_fn(tbl_mode, int'($urandom_range(0, DEPTH - 1)));
            else
                v = VAL_W'($urandom_range(0, 255));
            issue(v);
            await_result(lat);
            check_result("rand", v, lat);
            for (int c = $urandom_range(0, 2); c > 0; c--) begin
                check("rand_hold", res_valid, 1);
                @(negedge clock);
            end
            consume();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gentest_rsearch.md
Name: gentest_rsearch

Overview:
- Inverse of the combinational gentest lookup (idx -> value): given a target value, sequentially scans the lookup's index space and returns the lowest idx whose table value equals the target.
- Sits beside a gentest instance: drives its idx input and samples its value output one index per clock.
- Request and result use valid/ready handshakes, so a controller or testbench can issue searches back-to-back.

Parameters:
- IDX_W, 4, width of the table index.
- VAL_W, 8, width of the table value.
- DEPTH, 16, number of table entries scanned (1..2**IDX_W).

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  search request valid.
- req_ready  output  1  block idle and can accept a request.
- req_value  input  VAL_W  target value; captured on request accept.
- tbl_idx  output  IDX_W  index driven to the gentest idx input.
- tbl_value  input  VAL_W  gentest value output; combinational from tbl_idx.
- res_valid  output  1  result available.
- res_ready  input  1  result consumer accepts.
- res_found  output  1  1 = a match exists.
- res_idx  output  IDX_W  matching index (0 when res_found=0).
- busy  output  1  scan in progress.

Behaviour:
- Reset is async on reset_n low. Outputs under reset:
  - req_ready=0, res_valid=0, res_found=0, res_idx=0, tbl_idx=0, busy=0.
  - State returns to IDLE and any captured target is discarded.
  - First cycle after reset release: req_ready=1.
- States:
  - IDLE: req_ready=1, tbl_idx=0. On req_valid&req_ready, latch target=req_value, cnt=0 -> SCAN.
  - SCAN: busy=1, req_ready=0, tbl_idx=cnt. Each cycle compare tbl_value to target.
    - Equal: latch res_idx=cnt, res_found=1 -> DONE.
    - Not equal and cnt==DEPTH-1: res_found=0, res_idx=0 -> DONE.
    - Otherwise cnt++.
  - DONE: res_valid=1, result held stable, tbl_idx held. On res_valid&res_ready -> IDLE; res_valid=0 the next cycle.
- Latency from the accept edge to res_valid=1 is k+1 cycles when the match is at idx k; DEPTH cycles of SCAN when there is no match.
- Multiple matching entries: the lowest index wins; scanning stops at the first match.
- The counter never wraps. It is IDX_W bits wide and stops at DEPTH-1; the DEPTH==2**IDX_W case is handled without overflow.
- req_valid while busy or in DONE: ignored (req_ready=0); the requester must hold req_valid.
- res_ready asserted outside DONE: no effect.
- reset_n low mid-SCAN or in DONE: immediate abort. No res_valid is produced for the aborted request.
- tbl_value is sampled in the same cycle tbl_idx is driven; no internal pipelining of the table.

Test Plan:
- Bench table is value = idx*idx + 1 (mod 256); DEPTH=16.
- Reset then idle: reset_n low 3 cycles, release -> req_ready=1, res_valid=0, tbl_idx=0, busy=0.
- Match at first entry: req_value=1 -> res_valid after 1 SCAN cycle, res_found=1, res_idx=0.
- Mid-table and last-entry matches:
  - req_value=50 -> res_idx=7, res_valid 8 cycles after accept.
  - req_value=226 -> res_idx=15, res_valid 16 cycles after accept.
- No match: req_value=3 -> after 16 SCAN cycles, res_found=0, res_idx=0; tbl_idx visited 0..15 exactly once.
- Backpressure and blocked requests:
  - res_ready held low 5 cycles with req_valid asserted for req_value=10 -> res_valid/res_idx=7 stable, req_ready=0 throughout, table value for idx 7 is 50 (≠10).
  - After res_ready=1 -> second request accepted; result res_idx=3.
- Reset mid-scan: reset_n low at cnt=5 during req_value=226 -> outputs zero asynchronously, no res_valid.
  - A new req_value=17 after release -> res_idx=4.
